// File: rtl/status_src_sched.sv
`default_nettype none
// ============================================================================
// Module      : status_src_sched
// Description : Round-robin scheduler packing four 32-bit status sources into
//               6-byte packets for a status_router2 input channel.
// Revision    : 1.0 - initial release
// ============================================================================
module status_src_sched #(
    parameter logic [7:0] STATUS_ADDR0 = 8'h00,
    parameter logic [7:0] STATUS_ADDR1 = 8'h01,
    parameter logic [7:0] STATUS_ADDR2 = 8'h02,
    parameter logic [7:0] STATUS_ADDR3 = 8'h03
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_we,
    input  logic [1:0]   cmd_chn,
    input  logic [7:0]   cmd_data,
    input  logic [3:0]   src_ev,
    input  logic [127:0] src_data,
    output logic [7:0]   db,
    output logic         rq,
    input  logic         start,
    output logic         busy
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_REQ      = 2'd1;
    localparam logic [1:0] S_SEND     = 2'd2;
    localparam logic [2:0] C_LAST_IDX = 3'd5;

    logic [1:0]  r_state;
    logic [2:0]  r_idx;
    logic [39:0] r_sh;
    logic [1:0]  r_src;
    logic [1:0]  r_ptr;
    logic [1:0]  r_mode [4];
    logic [3:0]  r_pend;
    logic [5:0]  r_seq  [4];

    logic        w_found;
    logic        w_grant;
    logic [1:0]  w_win;
    logic [31:0] w_win_data;
    logic [1:0]  w_mode_nxt [4];
    logic [3:0]  w_pend_nxt;
    logic [5:0]  w_seq_nxt  [4];
    logic        w_unused;

    assign w_unused = ^cmd_data[7:3];

    // First pending source at or after the pointer, wrapping modulo 4.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int k = 0; k < 4; k++) begin
            if (!w_found && r_pend[r_ptr + 2'(k)]) begin
                w_found = 1'b1;
                w_win   = r_ptr + 2'(k);
            end
        end
    end

    assign w_grant    = (r_state == S_IDLE) && w_found;
    assign w_win_data = src_data[{w_win, 5'b0} +: 32];

    // Grant clears first, then events and command writes may set again.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int i = 0; i < 4; i++) begin
            w_mode_nxt[i] = r_mode[i];
            w_seq_nxt[i]  = r_seq[i];
            if (w_grant && (w_win == 2'(i))) begin
                w_pend_nxt[i] = 1'b0;
                w_seq_nxt[i]  = r_seq[i] + 6'd1;
                if (r_mode[i] == 2'd1) begin
                    w_mode_nxt[i] = 2'd0;
                end else if (r_mode[i] == 2'd3) begin
                    w_mode_nxt[i] = 2'd2;
                end
            end
            if (src_ev[i] && r_mode[i][1]) begin
                w_pend_nxt[i] = 1'b1;
            end
            if (cmd_we && (cmd_chn == 2'(i))) begin
                w_mode_nxt[i] = cmd_data[1:0];
                if (cmd_data[0]) begin
                    w_pend_nxt[i] = 1'b1;
                end else if (cmd_data[1:0] == 2'd0) begin
                    w_pend_nxt[i] = 1'b0;
                end
                if (cmd_data[2]) begin
                    w_seq_nxt[i] = 6'd0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= 3'd0;
            r_sh    <= 40'd0;
            r_src   <= 2'd0;
            r_ptr   <= 2'd0;
            r_pend  <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                r_mode[i] <= 2'd0;
                r_seq[i]  <= 6'd0;
            end
        end else begin
            r_pend <= w_pend_nxt;
            for (int i = 0; i < 4; i++) begin
                r_mode[i] <= w_mode_nxt[i];
                r_seq[i]  <= w_seq_nxt[i];
            end
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state <= S_REQ;
                        r_src   <= w_win;
                        r_ptr   <= w_win + 2'd1;
                        r_sh    <= {r_seq[w_win], w_win, w_win_data};
                    end
                end
                S_REQ: begin
                    if (start) begin
                        r_state <= S_SEND;
                        r_idx   <= 3'd1;
                    end
                end
                S_SEND: begin
                    // Byte under transmission always sits in the low lane.
                    r_sh  <= {8'h00, r_sh[39:8]};
                    r_idx <= r_idx + 3'd1;
                    if (r_idx == C_LAST_IDX) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        rq   = (r_state == S_REQ) || ((r_state == S_SEND) && (r_idx != C_LAST_IDX));
        db   = 8'h00;
        case (r_state)
            S_REQ: begin
                case (r_src)
                    2'd0:    db = STATUS_ADDR0;
                    2'd1:    db = STATUS_ADDR1;
                    2'd2:    db = STATUS_ADDR2;
                    default: db = STATUS_ADDR3;
                endcase
            end
            S_SEND:  db = r_sh[7:0];
            default: db = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_status_src_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_status_src_sched
// Description : Self-checking bench for status_src_sched (packet-level model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_status_src_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_we = 1'b0;
    logic [1:0]   cmd_chn = 2'd0;
    logic [7:0]   cmd_data = 8'h00;
    logic [3:0]   src_ev = 4'd0;
    logic [127:0] src_data = 128'd0;
    logic [7:0]   db;
    logic         rq;
    logic         start;
    logic         busy;
    logic         start_man = 1'b0;
    logic         start_auto = 1'b0;
    logic         auto_en = 1'b0;

    assign start = start_man | start_auto;

    status_src_sched dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_we   (cmd_we),
        .cmd_chn  (cmd_chn),
        .cmd_data (cmd_data),
        .src_ev   (src_ev),
        .src_data (src_data),
        .db       (db),
        .rq       (rq),
        .start    (start),
        .busy     (busy)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: pos -1 idle, 0 waiting for start, 1..5 byte index.
    int         m_mode [4];
    int         m_pend [4];
    int         m_seq  [4];
    int         m_ptr = 0;
    int         m_pos = -1;
    logic [7:0] m_pkt  [6];

    task automatic model_step();
        int win;
        int om [4];
        int c;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_mode[i] = 0; m_pend[i] = 0; m_seq[i] = 0;
            end
            m_ptr = 0;
            m_pos = -1;
            return;
        end
        win = -1;
        if (m_pos < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (win < 0 && m_pend[(m_ptr + k) % 4] != 0) win = (m_ptr + k) % 4;
            end
        end
        for (int i = 0; i < 4; i++) om[i] = m_mode[i];
        if (m_pos == 0) begin
            if (start) m_pos = 1;
        end else if (m_pos > 0) begin
            m_pos = (m_pos == 5) ? -1 : m_pos + 1;
        end
        if (win >= 0) begin
            m_pkt[0] = 8'(win);  // default STATUS_ADDRi equals i
            for (int b = 1; b <= 4; b++) m_pkt[b] = src_data[32*win + 8*(b-1) +: 8];
            m_pkt[5] = {6'(m_seq[win]), 2'(win)};
            m_seq[win]  = (m_seq[win] + 1) % 64;
            m_pend[win] = 0;
            if (om[win] == 1) m_mode[win] = 0;
            else if (om[win] == 3) m_mode[win] = 2;
            m_ptr = (win + 1) % 4;
            m_pos = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (src_ev[i] && om[i] >= 2) m_pend[i] = 1;
        end
        if (cmd_we) begin
            c = int'(cmd_chn);
            m_mode[c] = int'(cmd_data[1:0]);
            if (m_mode[c] == 1 || m_mode[c] == 3) m_pend[c] = 1;
            else if (m_mode[c] == 0) m_pend[c] = 0;
            if (cmd_data[2]) m_seq[c] = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("cyc_busy", 8'(busy), 8'(m_pos >= 0));
            chk("cyc_rq", 8'(rq), 8'(m_pos >= 0 && m_pos <= 4));
            chk("cyc_db", db, (m_pos >= 0) ? m_pkt[m_pos] : 8'h00);
        end
    end

    // Bus monitor and automatic start responder.
    int         npkt = 0;
    int         since_b5 = 100;
    logic       prev_rq = 1'b0;
    logic [7:0] b0_log [$];
    logic [7:0] b5_log [$];
    int         gap_log [$];

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            since_b5++;
            if (rq === 1'b1 && prev_rq === 1'b0) begin
                b0_log.push_back(db);
                gap_log.push_back(since_b5 - 1);
            end
            if (busy === 1'b1 && rq === 1'b0) begin
                b5_log.push_back(db);
                npkt++;
                since_b5 = 0;
            end
            start_auto = auto_en && (rq === 1'b1) && (prev_rq === 1'b0);
            prev_rq = rq;
        end
    end

    task automatic cmd(input logic [1:0] c, input logic [7:0] d);
        cmd_chn = c; cmd_data = d; cmd_we = 1'b1;
        @(negedge clk);
        cmd_we = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] m);
        src_ev = m;
        @(negedge clk);
        src_ev = 4'd0;
    endtask

    task automatic wait_npkt(input int target, input int budget, input string name);
        int n = 0;
        while (npkt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (npkt < target) chk(name, 8'(npkt), 8'(target));
    endtask

    task automatic wait_rq(input int budget, input string name);
        int n = 0;
        while (rq !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (rq !== 1'b1) chk(name, 8'(rq), 8'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int bi;
        logic [7:0] exp_b [4];
        exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        src_data = {32'h3333_3303, 32'h2222_2202, 32'h1111_1101, 32'hA1B2_C3D4};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("reset_rq", 8'(rq), 8'd0);
        chk("reset_db", db, 8'h00);
        chk("reset_busy", 8'(busy), 8'd0);

        // 1: single auto packet, start delayed three cycles
        cmd(2'd0, 8'h02);
        src_ev = 4'b0001;
        @(negedge clk);
        src_ev = 4'd0;
        chk("t1_rq_t1", 8'(rq), 8'd0);
        @(negedge clk);
        chk("t1_rq_t2", 8'(rq), 8'd1);
        chk("t1_b0", db, 8'h00);
        repeat (3) @(negedge clk);
        chk("t1_rq_hold", 8'(rq), 8'd1);
        start_man = 1'b1;
        @(negedge clk);
        start_man = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("t1_b%0d", j + 1), db, exp_b[j]);
            chk($sformatf("t1_rq_b%0d", j + 1), 8'(rq), 8'd1);
            @(negedge clk);
        end
        chk("t1_b5", db, 8'h00);
        chk("t1_rq_b5", 8'(rq), 8'd0);
        chk("t1_busy_b5", 8'(busy), 8'd1);
        @(negedge clk);
        chk("t1_busy_after", 8'(busy), 8'd0);

        // 2: all sources in mode 3 with seq cleared
        auto_en = 1'b1;
        base = npkt;
        bi = b0_log.size();
        for (int c = 0; c < 4; c++) cmd(2'(c), 8'h07);
        wait_npkt(base + 4, 100, "t2_timeout");
        repeat (20) @(negedge clk);
        chk("t2_count", 8'(npkt - base), 8'd4);
        for (int k = 0; k < 4; k++) begin
            if (b0_log.size() > bi + k) chk($sformatf("t2_b0_%0d", k), b0_log[bi + k], 8'(k));
            if (b5_log.size() > base + k) chk($sformatf("t2_b5_%0d", k), b5_log[base + k], 8'(k));
            if (k > 0 && gap_log.size() > bi + k)
                chk($sformatf("t2_gap_%0d", k), 8'(gap_log[bi + k]), 8'd1);
        end

        // 3: coalesced events during own packet; mode-0 source ignored
        cmd(2'd1, 8'h00);
        cmd(2'd2, 8'h06);
        base = npkt;
        pulse(4'b0100);
        wait_rq(10, "t3_rq_timeout");
        for (int k = 0; k < 5; k++) begin
            src_ev = 4'b0110;
            @(negedge clk);
        end
        src_ev = 4'd0;
        wait_npkt(base + 2, 60, "t3_timeout");
        repeat (20) @(negedge clk);
        chk("t3_count", 8'(npkt - base), 8'd2);
        if (b5_log.size() > base + 1) begin
            chk("t3_b5_first", b5_log[base], 8'h02);
            chk("t3_b5_follow", b5_log[base + 1], 8'h06);
        end

        // 4: single-shot mode reverts to off
        base = npkt;
        cmd(2'd1, 8'h01);
        wait_npkt(base + 1, 40, "t4_timeout");
        repeat (5) @(negedge clk);
        chk("t4_b0", b0_log[$], 8'h01);
        chk("t4_b5", b5_log[$], 8'h05);
        pulse(4'b0010);
        repeat (20) @(negedge clk);
        chk("t4_count", 8'(npkt - base), 8'd1);

        // 5: sequence wrap and explicit clear
        cmd(2'd3, 8'h06);
        base = npkt;
        for (int k = 0; k < 66; k++) begin
            pulse(4'b1000);
            wait_npkt(base + k + 1, 40, $sformatf("t5_timeout_%0d", k));
            if (b5_log.size() > base + k)
                chk($sformatf("t5_b5_%0d", k), b5_log[base + k], {6'(k % 64), 2'd3});
        end
        cmd(2'd3, 8'h06);
        base = npkt;
        pulse(4'b1000);
        wait_npkt(base + 1, 40, "t5_clr_timeout");
        chk("t5_b5_cleared", b5_log[$], 8'h03);
        repeat (3) @(negedge clk);

        // 6: reset mid-packet
        auto_en = 1'b0;
        base = npkt;
        pulse(4'b0001);
        wait_rq(10, "t6_rq_timeout");
        start_man = 1'b1;
        @(negedge clk);
        start_man = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_byte3", db, 8'hB2);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rq_rst", 8'(rq), 8'd0);
        chk("t6_busy_rst", 8'(busy), 8'd0);
        rst = 1'b0;
        auto_en = 1'b1;
        pulse(4'b1111);
        repeat (20) @(negedge clk);
        chk("t6_no_pkt", 8'(npkt - base), 8'd0);
        chk("t6_busy_idle", 8'(busy), 8'd0);
        cmd(2'd2, 8'h01);
        wait_npkt(base + 1, 40, "t6_reconf_timeout");
        chk("t6_reconf_b0", b0_log[$], 8'h02);
        chk("t6_reconf_b5", b5_log[$], 8'h02);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
